// File: rtl/rcc_cfg_pkg.sv
// Shared types for the RCC configuration initiator: op encoding, FSM states,
// the response payload and the POLL compare helper.
package rcc_cfg_pkg;

    localparam int unsigned CFG_AW = 32;
    localparam int unsigned CFG_DW = 32;

    typedef enum logic [1:0] {
        OP_WRITE = 2'd0,
        OP_READ  = 2'd1,
        OP_POLL  = 2'd2,
        OP_RSVD  = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2,
        ST_RSP  = 2'd3
    } state_e;

    typedef struct packed {
        logic [CFG_DW-1:0] rdata;
        logic              err;
    } rsp_t;

    // True when the read value equals the expected value on every masked bit.
    function automatic logic poll_match(input logic [CFG_DW-1:0] rdata,
                                        input logic [CFG_DW-1:0] data,
                                        input logic [CFG_DW-1:0] mask);
        return ((rdata ^ data) & mask) == '0;
    endfunction

endpackage

// File: rtl/rcc_cfg_if.sv
// Command, response and register-bus signals of the RCC configuration initiator.
// master = initiator side, slave = sequencer/register-file side.
interface rcc_cfg_if
    import rcc_cfg_pkg::*;
#(
    parameter int unsigned AW = CFG_AW,
    parameter int unsigned DW = CFG_DW,
    parameter int unsigned WW = DW / 8
);

    logic          cmd_valid;
    logic          cmd_ready;
    logic [1:0]    cmd_op;
    logic [AW-1:0] cmd_addr;
    logic [DW-1:0] cmd_data;
    logic [DW-1:0] cmd_mask;
    logic [WW-1:0] cmd_strb;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [WW-1:0] bus_wstrb;
    logic          bus_ack;
    logic [DW-1:0] bus_rdata;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, cmd_strb,
        input  rsp_ready, bus_ack, bus_rdata,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_mask, cmd_strb,
        output rsp_ready, bus_ack, bus_rdata,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  bus_req, bus_we, bus_addr, bus_wdata, bus_wstrb
    );

endinterface

// File: rtl/rcc_cfg_poll_timer.sv
// POLL bookkeeping: number of completed poll reads and idle cycles spent in the
// inter-read gap. gap_done_c/timeout_c are decoded from the counters.
module rcc_cfg_poll_timer #(
    parameter int unsigned POLL_TIMEOUT = 1024,
    parameter int unsigned POLL_GAP     = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic tick,
    input  logic clear,
    output logic gap_done_c,
    output logic timeout_c
);

    localparam int unsigned PW       = $clog2(POLL_TIMEOUT + 1);
    localparam int unsigned GW       = (POLL_GAP > 0) ? $clog2(POLL_GAP + 1) : 1;
    localparam int unsigned GAP_LAST = (POLL_GAP > 0) ? POLL_GAP - 1 : 0;

    logic [PW-1:0] poll_cnt;
    logic [GW-1:0] gap_cnt;

    // Both counters saturate so a stuck FSM can never wrap them.
    always_ff @(posedge clk) begin
        if (rst) begin
            poll_cnt <= '0;
            gap_cnt  <= '0;
        end else begin
            if (start) begin
                poll_cnt <= '0;
            end else if (tick && (poll_cnt != PW'(POLL_TIMEOUT))) begin
                poll_cnt <= poll_cnt + PW'(1);
            end

            if (clear) begin
                gap_cnt <= '0;
            end else if (gap_cnt != GW'(POLL_GAP)) begin
                gap_cnt <= gap_cnt + GW'(1);
            end
        end
    end

    // With POLL_GAP of 0 the single mandatory idle cycle is the whole gap.
    assign gap_done_c = (gap_cnt == GW'(GAP_LAST));
    // Asserted while the read now completing is the last one allowed.
    assign timeout_c  = (poll_cnt == PW'(POLL_TIMEOUT - 1));

endmodule

// File: rtl/rcc_cfg_initiator.sv
// Register-bus initiator for RCC bring-up: turns WRITE/READ/POLL commands into
// single-outstanding req/ack transactions and returns one response per command.
module rcc_cfg_initiator
    import rcc_cfg_pkg::*;
#(
    parameter int unsigned AW           = CFG_AW,
    parameter int unsigned DW           = CFG_DW,
    parameter int unsigned WW           = DW / 8,
    parameter int unsigned POLL_TIMEOUT = 1024,
    parameter int unsigned POLL_GAP     = 4
) (
    input  logic     clk,
    input  logic     rst,
    rcc_cfg_if.master io,
    output logic     busy
);

    state_e        state_q;
    op_e           op_q;
    logic [DW-1:0] data_q;
    logic [DW-1:0] mask_q;
    logic          cmd_ready_q;
    logic          rsp_valid_q;
    rsp_t          rsp_q;
    logic          bus_req_q;
    logic          bus_we_q;
    logic [AW-1:0] bus_addr_q;
    logic [DW-1:0] bus_wdata_q;
    logic [WW-1:0] bus_wstrb_q;
    logic          busy_q;

    op_e  op_c;
    logic accept_c;
    logic ack_c;
    logic tick_c;
    logic match_c;
    logic gap_clr_c;
    logic gap_done_c;
    logic timeout_c;

    assign op_c      = op_e'(io.cmd_op);
    assign accept_c  = (state_q == ST_IDLE) && cmd_ready_q && io.cmd_valid;
    // An ack only counts while a request is actually outstanding.
    assign ack_c     = (state_q == ST_BUS) && bus_req_q && io.bus_ack;
    assign tick_c    = ack_c && (op_q == OP_POLL);
    assign match_c   = poll_match(CFG_DW'(io.bus_rdata), CFG_DW'(data_q), CFG_DW'(mask_q));
    assign gap_clr_c = (state_q != ST_GAP);

    rcc_cfg_poll_timer #(
        .POLL_TIMEOUT (POLL_TIMEOUT),
        .POLL_GAP     (POLL_GAP)
    ) u_poll_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (accept_c),
        .tick       (tick_c),
        .clear      (gap_clr_c),
        .gap_done_c (gap_done_c),
        .timeout_c  (timeout_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_WRITE;
            data_q      <= '0;
            mask_q      <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_q       <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            bus_wstrb_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        op_q        <= op_c;
                        data_q      <= io.cmd_data;
                        mask_q      <= io.cmd_mask;
                        cmd_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        if (op_c == OP_RSVD) begin
                            state_q     <= ST_RSP;
                            rsp_valid_q <= 1'b1;
                            rsp_q       <= '{rdata: '0, err: 1'b1};
                        end else begin
                            state_q     <= ST_BUS;
                            bus_req_q   <= 1'b1;
                            bus_we_q    <= (op_c == OP_WRITE);
                            bus_addr_q  <= io.cmd_addr;
                            bus_wdata_q <= io.cmd_data;
                            bus_wstrb_q <= (op_c == OP_WRITE) ? io.cmd_strb : '1;
                        end
                    end
                end

                ST_BUS: begin
                    if (ack_c) begin
                        bus_req_q <= 1'b0;
                        unique case (op_q)
                            OP_WRITE: begin
                                state_q     <= ST_RSP;
                                rsp_valid_q <= 1'b1;
                                rsp_q       <= '{rdata: '0, err: 1'b0};
                            end
                            OP_READ: begin
                                state_q     <= ST_RSP;
                                rsp_valid_q <= 1'b1;
                                rsp_q       <= '{rdata: CFG_DW'(io.bus_rdata), err: 1'b0};
                            end
                            OP_POLL: begin
                                rsp_q.rdata <= CFG_DW'(io.bus_rdata);
                                if (match_c || timeout_c) begin
                                    state_q     <= ST_RSP;
                                    rsp_valid_q <= 1'b1;
                                    rsp_q.err   <= !match_c;
                                end else begin
                                    state_q <= ST_GAP;
                                end
                            end
                            OP_RSVD: begin
                                state_q     <= ST_RSP;
                                rsp_valid_q <= 1'b1;
                                rsp_q       <= '{rdata: '0, err: 1'b1};
                            end
                        endcase
                    end
                end

                // Bus stays idle here; the next poll read issues when the gap expires.
                ST_GAP: begin
                    if (gap_done_c) begin
                        state_q   <= ST_BUS;
                        bus_req_q <= 1'b1;
                    end
                end

                ST_RSP: begin
                    if (io.rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign io.cmd_ready = cmd_ready_q;
    assign io.rsp_valid = rsp_valid_q;
    assign io.rsp_rdata = DW'(rsp_q.rdata);
    assign io.rsp_err   = rsp_q.err;
    assign io.bus_req   = bus_req_q;
    assign io.bus_we    = bus_we_q;
    assign io.bus_addr  = bus_addr_q;
    assign io.bus_wdata = bus_wdata_q;
    assign io.bus_wstrb = bus_wstrb_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_rcc_cfg_initiator.sv
// Self-checking bench for rcc_cfg_initiator: directed bring-up sequences plus
// randomized commands against a transaction-level reference model.
module tb_rcc_cfg_initiator;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned WW = 4;
    localparam int unsigned PT = 8;
    localparam int unsigned PG = 4;
    localparam int BUDGET = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic busy;

    rcc_cfg_if #(.AW(AW), .DW(DW), .WW(WW)) io ();

    rcc_cfg_initiator #(
        .AW(AW), .DW(DW), .WW(WW), .POLL_TIMEOUT(PT), .POLL_GAP(PG)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .io   (io),
        .busy (busy)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Slave control and transaction log
    int          ack_lat   = 0;
    bit          ack_hold  = 1'b0;
    bit          noise     = 1'b0;
    logic [31:0] def_rdata = '0;
    logic [31:0] rd_q[$];
    logic [31:0] t_addr[$];
    bit          t_we[$];
    logic [31:0] t_wdata[$];
    logic [3:0]  t_wstrb[$];
    int          t_start[$];
    int          t_end[$];
    int          cyc = 0;
    int          scnt = 0;
    bit          in_txn = 1'b0;
    bit          just_acked = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Register-bus slave: acks after ack_lat cycles, logs and checks each request
    always @(negedge clk) begin
        cyc++;
        io.bus_ack   = 1'b0;
        io.bus_rdata = $urandom;
        if (just_acked && !rst) chk("bus_req_drop_after_ack", io.bus_req, 0);
        just_acked = 1'b0;
        if (rst) begin
            in_txn = 1'b0;
        end else if (io.bus_req) begin
            if (!in_txn) begin
                in_txn = 1'b1;
                scnt   = 0;
                t_addr.push_back(io.bus_addr);
                t_we.push_back(io.bus_we);
                t_wdata.push_back(io.bus_wdata);
                t_wstrb.push_back(io.bus_wstrb);
                t_start.push_back(cyc);
            end else begin
                scnt++;
                chk("bus_addr_stable", io.bus_addr, t_addr[$]);
                chk("bus_we_stable", io.bus_we, t_we[$]);
                chk("bus_wdata_stable", io.bus_wdata, t_wdata[$]);
                chk("bus_wstrb_stable", io.bus_wstrb, t_wstrb[$]);
            end
            if (!ack_hold && scnt >= ack_lat) begin
                io.bus_ack = 1'b1;
                if (rd_q.size() > 0) io.bus_rdata = rd_q.pop_front();
                else                 io.bus_rdata = def_rdata;
                t_end.push_back(cyc);
                in_txn     = 1'b0;
                just_acked = 1'b1;
            end
        end else begin
            in_txn = 1'b0;
            if (noise) io.bus_ack = ($urandom_range(0, 3) == 0);
        end
    end

    task automatic clear_log();
        t_addr.delete(); t_we.delete(); t_wdata.delete();
        t_wstrb.delete(); t_start.delete(); t_end.delete();
        rd_q.delete();
    endtask

    // Issue one command, check handshake/timing/response/bus log against the model
    task automatic do_cmd(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] data,
                          input logic [31:0] mask, input logic [3:0] strb, input int hold,
                          input string tag);
        int          n0, cnt, exp_nrd, nrd;
        logic [31:0] exp_rdata, r;
        logic        exp_err;

        exp_nrd = 0; exp_rdata = '0; exp_err = 1'b0;
        case (op)
            2'd0: exp_nrd = 1;
            2'd1: begin
                exp_nrd   = 1;
                exp_rdata = (rd_q.size() > 0) ? rd_q[0] : def_rdata;
            end
            2'd2: begin
                exp_err = 1'b1;
                for (int i = 0; i < int'(PT); i++) begin
                    r         = (i < rd_q.size()) ? rd_q[i] : def_rdata;
                    exp_nrd   = i + 1;
                    exp_rdata = r;
                    if ((r & mask) == (data & mask)) begin
                        exp_err = 1'b0;
                        break;
                    end
                end
            end
            default: exp_err = 1'b1;
        endcase

        n0 = t_addr.size();
        io.cmd_valid = 1'b1; io.cmd_op = op; io.cmd_addr = addr;
        io.cmd_data = data; io.cmd_mask = mask; io.cmd_strb = strb;
        chk({tag, ":cmd_ready_idle"}, io.cmd_ready, 1);
        @(negedge clk);
        io.cmd_valid = 1'b0; io.cmd_addr = $urandom; io.cmd_data = $urandom;
        io.cmd_mask = $urandom; io.cmd_strb = 4'($urandom);
        chk({tag, ":req_after_accept"}, io.bus_req, (op != 2'd3));
        chk({tag, ":cmd_ready_low"}, io.cmd_ready, 0);
        chk({tag, ":busy"}, busy, 1);

        cnt = 1;
        while (!io.rsp_valid && cnt < BUDGET) begin
            @(negedge clk);
            cnt++;
        end
        chk({tag, ":rsp_valid_within_budget"}, io.rsp_valid, 1);
        if (!io.rsp_valid) return;

        if (op == 2'd0 || op == 2'd1) chk({tag, ":accept_to_rsp"}, cnt, 2 + ack_lat);
        if (op == 2'd3)               chk({tag, ":accept_to_rsp"}, cnt, 1);
        chk({tag, ":rsp_rdata"}, io.rsp_rdata, exp_rdata);
        chk({tag, ":rsp_err"}, io.rsp_err, exp_err);
        chk({tag, ":cmd_ready_in_rsp"}, io.cmd_ready, 0);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({tag, ":hold_rsp_valid"}, io.rsp_valid, 1);
            chk({tag, ":hold_rsp_rdata"}, io.rsp_rdata, exp_rdata);
            chk({tag, ":hold_rsp_err"}, io.rsp_err, exp_err);
            chk({tag, ":hold_cmd_ready"}, io.cmd_ready, 0);
        end
        io.rsp_ready = 1'b1;
        @(negedge clk);
        io.rsp_ready = 1'b0;
        chk({tag, ":rsp_valid_cleared"}, io.rsp_valid, 0);
        chk({tag, ":cmd_ready_restored"}, io.cmd_ready, 1);
        chk({tag, ":busy_cleared"}, busy, 0);

        nrd = t_addr.size() - n0;
        chk({tag, ":bus_txn_count"}, nrd, exp_nrd);
        for (int i = 0; i < nrd && i < exp_nrd; i++) begin
            chk({tag, ":txn_addr"}, t_addr[n0 + i], addr);
            chk({tag, ":txn_we"}, t_we[n0 + i], (op == 2'd0));
            chk({tag, ":txn_wstrb"}, t_wstrb[n0 + i], (op == 2'd0) ? strb : 4'hF);
            if (op == 2'd0) chk({tag, ":txn_wdata"}, t_wdata[n0 + i], data);
            if (i > 0) chk({tag, ":poll_gap"}, t_start[n0 + i] - t_end[n0 + i - 1] - 1, PG);
        end
        rd_q.delete();
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a, d, m, v;
        int          n;

        io.cmd_valid = 1'b0; io.cmd_op = '0; io.cmd_addr = '0; io.cmd_data = '0;
        io.cmd_mask = '0; io.cmd_strb = '0; io.rsp_ready = 1'b0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", io.cmd_ready, 1);
        chk("rst_rsp_valid", io.rsp_valid, 0);
        chk("rst_rsp_rdata", io.rsp_rdata, 0);
        chk("rst_rsp_err", io.rsp_err, 0);
        chk("rst_bus_req", io.bus_req, 0);
        chk("rst_bus_we", io.bus_we, 0);
        chk("rst_bus_addr", io.bus_addr, 0);
        chk("rst_bus_wdata", io.bus_wdata, 0);
        chk("rst_bus_wstrb", io.bus_wstrb, 0);
        chk("rst_busy", busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // Directed bring-up sequence
        ack_lat = 2;
        do_cmd(2'd0, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 4'b0011, 1, "write");
        ack_lat = 0;
        do_cmd(2'd0, 32'h0000_0020, 32'h1234_5678, 32'h0, 4'hF, 0, "write_zero_wait");
        ack_lat = 1;
        rd_q.push_back(32'h0000_0003);
        do_cmd(2'd1, 32'h0000_0014, 32'h0, 32'h0, 4'h0, 2, "read");
        ack_lat = 0; def_rdata = '0;
        rd_q = '{32'h0, 32'h0, 32'h0, 32'h2};
        do_cmd(2'd2, 32'h0000_0018, 32'h2, 32'h2, 4'h0, 0, "poll_match");
        def_rdata = '0;
        do_cmd(2'd2, 32'h0000_001C, 32'h1, 32'h1, 4'h0, 1, "poll_timeout");
        def_rdata = 32'hA5C3_0F96;
        do_cmd(2'd2, 32'h0000_0040, 32'h5A5A_1234, 32'h0, 4'h0, 0, "poll_mask0");
        noise = 1'b1;
        do_cmd(2'd3, 32'h0000_0044, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hF, 5, "reserved");

        // Reset while a transaction waits for its ack
        ack_hold = 1'b1; noise = 1'b0;
        io.cmd_valid = 1'b1; io.cmd_op = 2'd0; io.cmd_addr = 32'h30;
        io.cmd_data = 32'h1; io.cmd_strb = 4'hF;
        @(negedge clk);
        io.cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("pre_rst_bus_req", io.bus_req, 1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_bus_req", io.bus_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_cmd_ready", io.cmd_ready, 1);
        chk("mid_rst_rsp_valid", io.rsp_valid, 0);
        rst = 1'b0; ack_hold = 1'b0;
        clear_log();
        @(negedge clk);
        ack_lat = 1;
        do_cmd(2'd0, 32'h0000_0030, 32'h0000_00FF, 32'h0, 4'b0001, 0, "write_after_rst");

        // Randomized commands with spurious idle-bus acks
        noise = 1'b1;
        for (int it = 0; it < 24; it++) begin
            op = 2'($urandom_range(0, 3));
            a  = $urandom & 32'hFFFF_FFFC;
            d  = $urandom;
            m  = ($urandom_range(0, 4) == 0) ? 32'h0 : ($urandom & $urandom);
            ack_lat   = $urandom_range(0, 3);
            def_rdata = $urandom;
            rd_q.delete();
            if (op == 2'd1 && $urandom_range(0, 1) == 1) rd_q.push_back($urandom);
            if (op == 2'd2) begin
                n = $urandom_range(0, 9);
                for (int j = 0; j < n; j++) rd_q.push_back((d & m) ^ (m & $urandom));
                v = (d & m) | (~m & $urandom);
                if ($urandom_range(0, 1) == 1) rd_q.push_back(v);
            end
            do_cmd(op, a, d, m, 4'($urandom), $urandom_range(0, 3), "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/rcc_cfg_initiator.md
Name: rcc_cfg_initiator

Overview:
- Register-bus initiator that drives RCC configuration traffic: the requesting end of the req/ack register interface that the RCC register file answers.
- Accepts a command stream of WRITE, READ and POLL operations and converts each into one or more single-outstanding bus transactions.
- Returns one response per command.
- Sits between the boot/power-management sequencer and the RCC register port. Used for clock/reset bring-up, e.g. enable oscillator, poll ready, release domain resets.

Parameters:
- AW, 32, bus address width
- DW, 32, bus data width
- WW, DW/8, byte-strobe width
- POLL_TIMEOUT, 1024, maximum POLL bus reads before error; must be >= 1
- POLL_GAP, 4, idle cycles between successive POLL reads; 0 allowed

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when valid&ready
- cmd_op  in  2  0=WRITE 1=READ 2=POLL 3=reserved
- cmd_addr  in  AW  register address
- cmd_data  in  DW  write data / POLL expected value
- cmd_mask  in  DW  POLL compare mask
- cmd_strb  in  WW  WRITE byte strobes
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed when valid&ready
- rsp_rdata  out  DW  last read data (0 for WRITE)
- rsp_err  out  1  1 = POLL timeout or reserved op
- bus_req  out  1  transaction request
- bus_we  out  1  1=write
- bus_addr  out  AW  address
- bus_wdata  out  DW  write data
- bus_wstrb  out  WW  byte strobes
- bus_ack  in  1  transaction complete; rdata valid same cycle
- bus_rdata  in  DW  read data
- busy  out  1  state != IDLE

Behaviour:
- Reset values:
  - cmd_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, bus_req=0, bus_we=0.
  - bus_addr, bus_wdata, bus_wstrb = 0; busy=0.
  - Poll and gap counters = 0; state=IDLE.
- Reset mid-operation abandons any bus_req and pending response immediately. The bus slave tolerates a dropped req.
- FSM states: IDLE, BUS, GAP, RSP.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, register op/addr/data/mask/strb and drop cmd_ready.
  - op=3: go to RSP with rsp_err=1 and rsp_rdata=0; no bus activity.
  - Otherwise go to BUS. bus_req rises the cycle after acceptance (accept-to-req latency 1).
- BUS:
  - bus_req, bus_we, bus_addr, bus_wdata and bus_wstrb are held stable until a cycle with bus_ack=1.
  - bus_we=1 only for WRITE. bus_wstrb = cmd_strb for WRITE, all-ones for reads.
  - bus_ack while bus_req=0 is ignored.
  - bus_req deasserts in the cycle after ack; back-to-back transactions always have at least one idle cycle.
  - On ack, WRITE: go to RSP with rdata=0, err=0.
  - On ack, READ: capture bus_rdata, go to RSP with err=0.
  - On ack, POLL: capture bus_rdata and increment poll count (width clog2(POLL_TIMEOUT+1)), then:
    - if (bus_rdata & mask) == (data & mask): go to RSP, err=0;
    - else if count == POLL_TIMEOUT: go to RSP, err=1, rdata = last read value;
    - else go to GAP (or straight back to BUS with a new req next cycle if POLL_GAP=0).
- GAP:
  - Count POLL_GAP cycles, then go to BUS.
  - Gap counter clears on entry.
- RSP:
  - rsp_valid=1; rsp_rdata and rsp_err are stable while rsp_valid & !rsp_ready.
  - On rsp_ready: go to IDLE, rsp_valid=0 next cycle, cmd_ready=1 next cycle.
  - No overlap: a new command is never accepted in the same cycle the response is consumed.
- Command throughput: a WRITE with zero-wait ack completes accept->rsp_valid in 3 cycles (accept, req+ack, rsp).
- A POLL whose mask=0 matches on the first read.
- busy=1 in BUS, GAP, RSP.

Decomposition:
- Shared package rcc_cfg_pkg:
  - op encoding enum (OP_WRITE, OP_READ, OP_POLL, OP_RSVD);
  - FSM state enum;
  - response struct.
- One natural sub-module: rcc_cfg_poll_timer. It holds the poll-count and gap counters, with inputs start/tick/clear and outputs gap_done/timeout. The FSM stays in rcc_cfg_initiator.

Test Plan:
- Reset, then WRITE addr=0x0000_0010 data=0xDEAD_BEEF strb=4'b0011, ack 2 cycles after req -> one bus write with exactly those values held stable until ack; rsp_valid with rdata=0, err=0.
- READ addr=0x14 with bus_rdata=0x0000_0003 at ack -> bus_we=0, wstrb=4'hF; rsp_rdata=0x3, err=0.
- POLL addr=0x18 mask=0x2 data=0x2, slave returns 0x0 three times then 0x2 -> exactly 4 bus reads, each separated by at least POLL_GAP=4 idle cycles; rsp rdata=0x2, err=0.
- POLL with POLL_TIMEOUT=8, slave always 0x0 -> exactly 8 reads; rsp_err=1, rsp_rdata=0.
- op=3 -> no bus_req ever; rsp_err=1. Hold rsp_ready=0 for 5 cycles -> rsp fields stable and cmd_ready=0 throughout.
- Assert rst during BUS with ack withheld -> next cycle bus_req=0, busy=0, cmd_ready=1. A subsequent WRITE completes normally.
